// File: rtl/ped_crossing_scheduler.sv
// Pedestrian crossing scheduler: holds the traffic FSM in RED, runs WALK/flash WALK, then enforces a vehicle gap.
// Optional crossings-served counter is built when SVC_COUNT_EN is defined.
module ped_crossing_scheduler #(
    parameter int TMR_W      = 8,
    parameter int CLEAR_CYC  = 4,
    parameter int WALK_CYC   = 16,
    parameter int FLASH_CYC  = 8,
    parameter int FLASH_HALF = 2,
    parameter int GAP_CYC    = 32
`ifdef SVC_COUNT_EN
    ,
    parameter int CNT_W      = 8
`endif
) (
    input  logic             clk_main,
    input  logic             rst_main_n,
    input  logic             ped_req,
    input  logic [1:0]       traffic_light,
    output logic             hold_red,
    output logic             walk,
    output logic             wait_lamp,
    output logic             ped_ack
`ifdef SVC_COUNT_EN
    ,
    output logic [CNT_W-1:0] svc_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WALK,
        S_FLASH,
        S_RECOVER
    } state_t;

    localparam logic [1:0]       LIGHT_RED  = 2'b10;
    localparam logic [TMR_W-1:0] CLEAR_LAST = TMR_W'(CLEAR_CYC - 1);
    localparam logic [TMR_W-1:0] WALK_LAST  = TMR_W'(WALK_CYC - 1);
    localparam logic [TMR_W-1:0] FLASH_LAST = TMR_W'(FLASH_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0] FLASH_DIV  = TMR_W'(FLASH_HALF);

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               pending_q, pending_d;
    logic               hold_q, hold_d;
    logic               walk_q, walk_d;
    logic               ack_q, ack_d;
    logic               enter_walk;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pending_d  = pending_q;
        walk_d     = 1'b0;
        enter_walk = 1'b0;

        if (ped_req && (state_q != S_WALK)) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (pending_q || ped_req) begin
                    state_d = S_CLEAR;
                    timer_d = '0;
                end
            end
            S_CLEAR: begin
                // Any non-RED sample (including the illegal code) restarts the confirmation count.
                if (traffic_light == LIGHT_RED) begin
                    if (timer_q == CLEAR_LAST) begin
                        state_d    = S_WALK;
                        timer_d    = '0;
                        walk_d     = 1'b1;
                        enter_walk = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end else begin
                    timer_d = '0;
                end
            end
            S_WALK: begin
                if (timer_q == WALK_LAST) begin
                    state_d = S_FLASH;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                    walk_d  = 1'b1;
                end
            end
            S_FLASH: begin
                if (timer_q == FLASH_LAST) begin
                    state_d = S_RECOVER;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                    // Lamp level for the next cycle: odd half-periods are lit.
                    walk_d  = (((timer_q + 1'b1) / FLASH_DIV) & TMR_W'(1)) != '0;
                end
            end
            S_RECOVER: begin
                if (timer_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        if (enter_walk) begin
            pending_d = 1'b0;
        end
        ack_d  = enter_walk;
        hold_d = (state_d == S_CLEAR) || (state_d == S_WALK) || (state_d == S_FLASH);
    end

    always_ff @(posedge clk_main or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            pending_q <= 1'b0;
            hold_q    <= 1'b0;
            walk_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            hold_q    <= hold_d;
            walk_q    <= walk_d;
            ack_q     <= ack_d;
        end
    end

    assign hold_red  = hold_q;
    assign walk      = walk_q;
    assign wait_lamp = pending_q;
    assign ped_ack   = ack_q;

`ifdef SVC_COUNT_EN
    logic [CNT_W-1:0] svc_count_q, svc_count_d;

    always_comb begin
        svc_count_d = svc_count_q;
        if (enter_walk && (svc_count_q != '1)) begin
            svc_count_d = svc_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_main or negedge rst_main_n) begin
        if (!rst_main_n) begin
            svc_count_q <= '0;
        end else begin
            svc_count_q <= svc_count_d;
        end
    end

    assign svc_count = svc_count_q;
`endif

endmodule
